ias_dft_ctrl: RTL
=================

# ias_dft_ctrl

Command-driven sequencer for the IAS 32-bit scannable counter datapath. Owns every datapath control pin: functional load, N-cycle increment runs, and 32-cycle scan-chain read (non-destructive) and write (swap). Sits between the DUFT host-side command interface and the datapath. Every accepted command yields exactly one response.

## Interface
- WIDTH, 32, scan-chain / data width; fixed at 32 for IAS.
- CNT_W, 16, width of the RUN cycle count taken from cmd_data[CNT_W-1:0].

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; also drives the datapath reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  in  2  0=LOAD, 1=RUN, 2=SCAN_RD, 3=SCAN_WR.
- cmd_data  in  WIDTH  LOAD value / RUN count (low CNT_W bits) / SCAN_WR word.
- rsp_valid  out  1  response available; held until taken.
- rsp_ready  in  1  response taken on the edge where rsp_valid && rsp_ready.
- rsp_data  out  WIDTH  captured chain contents (SCAN_RD/SCAN_WR); 0 for LOAD/RUN.
- busy  out  1  state != IDLE.
- dp_data_in  out  WIDTH  datapath load value.
- dp_reg_en  out  1  datapath functional clock-enable.
- dp_reg_sel  out  1  1=load dp_data_in, 0=increment.
- dp_sen  out  1  scan enable.
- dp_scan_ce  out  1  scan clock-enable.
- dp_sin  out  1  scan input.
- dp_sout  in  1  scan output (datapath bit 31).

## Operation
- States: IDLE, LOAD, RUN, SHIFT, RESP.
- IDLE: cmd_ready=1; all dp_* controls 0. On accept, latch op/data, then:
  - LOAD → LOAD; RUN with count 0 → RESP; RUN with count N>0 → RUN (down-counter = N); SCAN_RD/SCAN_WR → SHIFT (bit counter = 0).
- LOAD (1 cycle): dp_reg_en=1, dp_reg_sel=1, dp_data_in=latched word. → RESP.
- RUN: dp_reg_en=1, dp_reg_sel=0 each cycle; counter decrements; leave to RESP after the cycle where counter==1. Datapath advances by exactly N, mod 2^32.
- SHIFT (32 cycles): dp_sen=1, dp_scan_ce=1, dp_reg_en=0. Chain contract: sout=q[31], sin enters q[0], MSB first.
  - Each cycle: capture <= {capture[30:0], dp_sout}.
  - SCAN_RD: dp_sin = dp_sout (combinational recirculation); register is unchanged after 32 shifts.
  - SCAN_WR: dp_sin = wr_shift[31]; wr_shift shifts left each cycle; after 32 shifts the register holds cmd_data, and capture holds the old contents.
  - After the bit-counter==31 cycle → RESP.
- RESP: rsp_valid=1; rsp_data stable while !rsp_ready; on handshake → IDLE.
- dp_sen, dp_scan_ce, dp_reg_en are never high simultaneously.

## Timing
- Reset (asynchronous): state=IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, busy=0; all dp_* outputs 0; counters and capture cleared.
- Reset mid-operation aborts the command with no response. Datapath is cleared by the same reset.
- All outputs are registered/state-decoded except dp_sin during SCAN_RD.
- Latency from the accept edge to the first rsp_valid cycle: LOAD 2, RUN N → N+1 (N=0 → 1), SCAN_RD/SCAN_WR 33.
- Back-to-back: cmd_ready returns 1 in the cycle after the response handshake. Commands offered while busy are not accepted; cmd_valid may stay high.
- rsp_ready held high: RESP lasts exactly 1 cycle.
- RUN count uses only cmd_data[CNT_W-1:0]; upper bits ignored.

## Test plan
- Reset then LOAD 0x0000_00FF → datapath q=0x0000_00FF the cycle after LOAD state; rsp_data=0 at cycle 2.
- LOAD 0xFFFF_FFFE, RUN 3 → q wraps to 0x0000_0001; rsp_valid 4 cycles after accept; RUN 0 → rsp_valid at cycle 1, q unchanged.
- LOAD 0xA5A5_1234, SCAN_RD → rsp_data=0xA5A5_1234 at cycle 33; second SCAN_RD returns the same value; dp_reg_en=0 throughout.
- After LOAD 0xDEAD_BEEF, SCAN_WR 0x1234_5678 → rsp_data=0xDEAD_BEEF; a following SCAN_RD returns 0x1234_5678.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_data stable, cmd_ready=0, a pending cmd_valid not accepted; accepted the cycle after the handshake.
- Assert reset at shift bit 10 of SCAN_WR → immediate IDLE, all outputs 0, no response; next SCAN_RD returns 0x0000_0000.

Source files
------------

// File: rtl/ias_dft_ctrl.sv
// Command sequencer for the IAS 32-bit scannable counter datapath: functional load,
// N-cycle increment runs and 32-cycle scan read/write, one response per accepted command.
module ias_dft_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] dp_data_in,
  output logic             dp_reg_en,
  output logic             dp_reg_sel,
  output logic             dp_sen,
  output logic             dp_scan_ce,
  output logic             dp_sin,
  input  logic             dp_sout
);

  localparam int unsigned BitW = $clog2(WIDTH);

  localparam logic [1:0] OpLoad   = 2'd0;
  localparam logic [1:0] OpRun    = 2'd1;
  localparam logic [1:0] OpScanRd = 2'd2;
  localparam logic [1:0] OpScanWr = 2'd3;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StShift, StResp} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] wr_shift_q;
  logic [WIDTH-1:0] dp_data_in_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic             dp_reg_en_q;
  logic             dp_reg_sel_q;
  logic             dp_sen_q;
  logic             dp_scan_ce_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpLoad;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      capture_q    <= '0;
      wr_shift_q   <= '0;
      dp_data_in_q <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      dp_reg_en_q  <= 1'b0;
      dp_reg_sel_q <= 1'b0;
      dp_sen_q     <= 1'b0;
      dp_scan_ce_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            wr_shift_q  <= cmd_data;
            capture_q   <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            unique case (cmd_op)
              OpLoad: begin
                state_q      <= StLoad;
                dp_reg_en_q  <= 1'b1;
                dp_reg_sel_q <= 1'b1;
                dp_data_in_q <= cmd_data;
              end
              OpRun: begin
                if (cmd_data[CNT_W-1:0] == '0) begin
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                end else begin
                  state_q      <= StRun;
                  cnt_q        <= cmd_data[CNT_W-1:0];
                  dp_reg_en_q  <= 1'b1;
                  dp_reg_sel_q <= 1'b0;
                end
              end
              OpScanRd, OpScanWr: begin
                state_q      <= StShift;
                bit_cnt_q    <= '0;
                dp_sen_q     <= 1'b1;
                dp_scan_ce_q <= 1'b1;
              end
            endcase
          end
        end
        StLoad: begin
          dp_reg_en_q  <= 1'b0;
          dp_reg_sel_q <= 1'b0;
          dp_data_in_q <= '0;
          state_q      <= StResp;
          rsp_valid_q  <= 1'b1;
        end
        StRun: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            dp_reg_en_q <= 1'b0;
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end
        end
        StShift: begin
          // The chain shifts MSB first, so capture ends up holding the old word in order.
          capture_q  <= {capture_q[WIDTH-2:0], dp_sout};
          wr_shift_q <= {wr_shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_q  <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitW'(WIDTH - 1)) begin
            dp_sen_q     <= 1'b0;
            dp_scan_ce_q <= 1'b0;
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Scan read recirculates sout straight back into sin so the register survives the read.
  always_comb begin
    dp_sin = 1'b0;
    if (state_q == StShift) begin
      dp_sin = (op_q == OpScanWr) ? wr_shift_q[WIDTH-1] : dp_sout;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = capture_q;
  assign busy       = busy_q;
  assign dp_data_in = dp_data_in_q;
  assign dp_reg_en  = dp_reg_en_q;
  assign dp_reg_sel = dp_reg_sel_q;
  assign dp_sen     = dp_sen_q;
  assign dp_scan_ce = dp_scan_ce_q;

endmodule
